// File: rtl/i2s_tx_master_if.sv
// Sample-pair stream into the I2S transmitter: left/right words with a
// valid/ready handshake. The producer uses the master modport, the
// transmitter the slave modport.
interface i2s_tx_master_if #(
  parameter int SAMPLE_W = 24
);
  logic [SAMPLE_W-1:0] l_data;
  logic [SAMPLE_W-1:0] r_data;
  logic                s_valid;
  logic                s_ready;

  modport master (
    output l_data,
    output r_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  l_data,
    input  r_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/i2s_tx_master.sv
// I2S / left-justified transmitter, bus master (drives bclk and wclk).
// A free-running divider produces bclk. On every bclk falling edge the
// slot counter advances, and wclk, sdata and the frame load update.
// A one-pair holding register decouples the sample stream from frame timing.
// When a frame starts with the holding register empty, silence is sent and
// underrun pulses for one cycle.
module i2s_tx_master #(
  parameter int CLK_DIV  = 128,
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int MODE     = 0
) (
  input  logic             adc_clk,
  input  logic             rst,
  i2s_tx_master_if.slave   s_if,
  output logic             i2s_bclk,
  output logic             i2s_wclk,
  output logic             i2s_sdata,
  output logic             underrun
);

  localparam int CW  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int BW  = (SLOT_W   > 1) ? $clog2(SLOT_W)   : 1;
  localparam int IW  = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam int DLY = (MODE == 0) ? 1 : 0;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(SLOT_W - 1);

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_t;

  hold_t               hold_state;
  hold_t               hold_next;

  logic [CW-1:0]       clk_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       bit_nxt;
  logic                wclk_nxt;
  logic                cnt_wrap;
  logic                fall_evt;
  logic                frame_start;
  logic                accept;

  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic [SAMPLE_W-1:0] l_word;
  logic [SAMPLE_W-1:0] r_word;
  logic [SAMPLE_W-1:0] l_nxt;
  logic [SAMPLE_W-1:0] r_nxt;
  logic [SAMPLE_W-1:0] chan_word;
  logic                sdata_nxt;
  int                  d;

  assign cnt_wrap    = (clk_cnt == CNT_MAX);
  assign fall_evt    = cnt_wrap && i2s_bclk;
  assign frame_start = fall_evt && (bit_cnt == BIT_MAX) && i2s_wclk;
  assign accept      = s_if.s_valid && (hold_state == HOLD_EMPTY);
  assign s_if.s_ready = (hold_state == HOLD_EMPTY);

  // Bit-clock divider: toggle bclk each time the cycle counter wraps.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      clk_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (cnt_wrap) begin
      clk_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      clk_cnt  <= clk_cnt + CW'(1);
    end
  end

  // Slot position and word clock that take effect on the next falling edge.
  always_comb begin
    bit_nxt  = bit_cnt;
    wclk_nxt = i2s_wclk;
    if (bit_cnt == BIT_MAX) begin
      bit_nxt  = '0;
      wclk_nxt = ~i2s_wclk;
    end else begin
      bit_nxt  = bit_cnt + BW'(1);
    end
  end

  // Holding register state: a frame start empties it, and a handshake fills it.
  always_comb begin
    hold_next = hold_state;
    if (frame_start && (hold_state == HOLD_FULL)) begin
      hold_next = HOLD_EMPTY;
    end else if (accept) begin
      hold_next = HOLD_FULL;
    end
  end

  // Frame load values and the next serial bit, taken from the channel word
  // that will be current after the edge.
  always_comb begin
    l_nxt     = '0;
    r_nxt     = '0;
    sdata_nxt = 1'b0;
    if (hold_state == HOLD_FULL) begin
      l_nxt = hold_l;
      r_nxt = hold_r;
    end
    // A frame start loads a new left word in the same edge that the new
    // word's first bit goes out, so the bit comes from the load value.
    if (frame_start) begin
      chan_word = l_nxt;
    end else if (wclk_nxt) begin
      chan_word = r_word;
    end else begin
      chan_word = l_word;
    end
    d = int'(bit_nxt) - DLY;
    if ((d >= 0) && (d < SAMPLE_W)) begin
      sdata_nxt = chan_word[IW'(SAMPLE_W - 1 - d)];
    end
  end

  // Holding register: captures a pair on handshake, and reset discards it.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      hold_state <= HOLD_EMPTY;
      hold_l     <= '0;
      hold_r     <= '0;
    end else begin
      hold_state <= hold_next;
      if (accept) begin
        hold_l <= s_if.l_data;
        hold_r <= s_if.r_data;
      end
    end
  end

  // Serial-side state, updated only on bclk falling-edge events.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      bit_cnt   <= BIT_MAX;
      i2s_wclk  <= 1'b1;
      i2s_sdata <= 1'b0;
      l_word    <= '0;
      r_word    <= '0;
    end else if (fall_evt) begin
      bit_cnt   <= bit_nxt;
      i2s_wclk  <= wclk_nxt;
      i2s_sdata <= sdata_nxt;
      if (frame_start) begin
        l_word <= l_nxt;
        r_word <= r_nxt;
      end
    end
  end

  // Underrun pulse: asserted for one cycle when a frame starts with nothing held.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else begin
      underrun <= frame_start && (hold_state == HOLD_EMPTY);
    end
  end

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: one MODE=0 and one MODE=1 instance driven with
// identical streams. Expected outputs come from a time-based frame model:
// bclk, wclk and the bit position are derived arithmetically from the cycle
// count since reset release, and accepted pairs are queued per frame.
module tb_i2s_tx_master;

  localparam int C = 2;
  localparam int W = 4;
  localparam int S = 8;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [7:0]   m0l;
    logic [7:0]   m0r;
    logic [7:0]   m1l;
    logic [7:0]   m1r;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] l_data = '0;
  logic [W-1:0] r_data = '0;
  logic         s_valid = 1'b0;

  logic bclk0, wclk0, sd0, und0;
  logic bclk1, wclk1, sd1, und1;

  i2s_tx_master_if #(.SAMPLE_W(W)) if0 ();
  i2s_tx_master_if #(.SAMPLE_W(W)) if1 ();

  assign if0.l_data  = l_data;
  assign if0.r_data  = r_data;
  assign if0.s_valid = s_valid;
  assign if1.l_data  = l_data;
  assign if1.r_data  = r_data;
  assign if1.s_valid = s_valid;

  i2s_tx_master #(.CLK_DIV(C), .SAMPLE_W(W), .SLOT_W(S), .MODE(0)) dut0 (
    .adc_clk(clk), .rst(rst), .s_if(if0),
    .i2s_bclk(bclk0), .i2s_wclk(wclk0), .i2s_sdata(sd0), .underrun(und0)
  );

  i2s_tx_master #(.CLK_DIV(C), .SAMPLE_W(W), .SLOT_W(S), .MODE(1)) dut1 (
    .adc_clk(clk), .rst(rst), .s_if(if1),
    .i2s_bclk(bclk1), .i2s_wclk(wclk1), .i2s_sdata(sd1), .underrun(und1)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               t        = 0;
  logic [2*W-1:0]   pending[$];
  logic [W-1:0]     frm_l = '0;
  logic [W-1:0]     frm_r = '0;
  bit               exp_und = 1'b0;
  bit               last_acc = 1'b0;
  bit               cap0[0:1023];
  bit               cap1[0:1023];
  vec_t             vecs[3];

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0d expected=%0d", name, t, act, exp_v);
    end
  endtask

  function automatic bit exp_sd(input int mode);
    int n, k, pos, p, dd;
    logic [W-1:0] w;
    n = t / (2 * C);
    if (n == 0) return 1'b0;
    k   = n - 1;
    pos = k % (2 * S);
    p   = pos % S;
    w   = (pos >= S) ? frm_r : frm_l;
    dd  = p - ((mode == 0) ? 1 : 0);
    if (dd < 0 || dd >= W) return 1'b0;
    return w[W - 1 - dd];
  endfunction

  function automatic bit exp_wclk();
    int n;
    n = t / (2 * C);
    if (n == 0) return 1'b1;
    return (((n - 1) % (2 * S)) >= S);
  endfunction

  function automatic bit is_frame_start();
    int n;
    if ((t % (2 * C)) != 0) return 1'b0;
    n = t / (2 * C);
    return (n >= 1) && (((n - 1) % (2 * S)) == 0);
  endfunction

  // One adc_clk cycle: advance the model across the edge, then compare.
  task automatic step();
    bit acc;
    int k;
    logic [2*W-1:0] pr;
    acc = s_valid && (pending.size() == 0) && !rst;
    @(posedge clk);
    #1;
    last_acc = 1'b0;
    if (rst) begin
      t = 0;
      pending.delete();
      frm_l = '0;
      frm_r = '0;
      exp_und = 1'b0;
      chk("rst_bclk0", int'(bclk0), 0);
      chk("rst_wclk0", int'(wclk0), 1);
      chk("rst_sd0", int'(sd0), 0);
      chk("rst_und0", int'(und0), 0);
      chk("rst_ready0", int'(if0.s_ready), 1);
      chk("rst_sd1", int'(sd1), 0);
      chk("rst_ready1", int'(if1.s_ready), 1);
    end else begin
      t++;
      exp_und = 1'b0;
      if (is_frame_start()) begin
        if (pending.size() > 0) begin
          pr = pending.pop_front();
          frm_l = pr[2*W-1:W];
          frm_r = pr[W-1:0];
        end else begin
          frm_l = '0;
          frm_r = '0;
          exp_und = 1'b1;
        end
      end
      if (acc) begin
        pending.push_back({l_data, r_data});
        last_acc = 1'b1;
      end
      if ((t % (2 * C)) == 0) begin
        k = t / (2 * C) - 1;
        if (k < 1024) begin
          cap0[k] = sd0;
          cap1[k] = sd1;
        end
      end
      chk("bclk0", int'(bclk0), (t / C) % 2);
      chk("bclk1", int'(bclk1), (t / C) % 2);
      chk("wclk0", int'(wclk0), int'(exp_wclk()));
      chk("wclk1", int'(wclk1), int'(exp_wclk()));
      chk("sdata0", int'(sd0), int'(exp_sd(0)));
      chk("sdata1", int'(sd1), int'(exp_sd(1)));
      chk("underrun0", int'(und0), int'(exp_und));
      chk("underrun1", int'(und1), int'(exp_und));
      chk("ready0", int'(if0.s_ready), int'(pending.size() == 0));
      chk("ready1", int'(if1.s_ready), int'(pending.size() == 0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_to(input int tt);
    while (t < tt) step();
  endtask

  // Present one pair until accepted, bounded by a cycle budget.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    int budget;
    l_data = l;
    r_data = r;
    s_valid = 1'b1;
    budget = 200;
    do begin
      step();
      budget--;
    end while (!last_acc && budget > 0);
    if (!last_acc) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  function automatic logic [7:0] slot_byte(input int which, input int base);
    logic [7:0] b;
    for (int p = 0; p < 8; p++) begin
      b[7 - p] = (which == 0) ? cap0[base + p] : cap1[base + p];
    end
    return b;
  endfunction

  function automatic logic [W-1:0] word1(input int base);
    logic [W-1:0] w;
    for (int p = 0; p < W; p++) w[W - 1 - p] = cap1[base + p];
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d actual=timeout expected=finish", t);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pl[3];
    logic [W-1:0] prr[3];
    int           und_cnt;
    int           acc_t[3];
    int           idx;

    vecs[0] = '{l: 4'hA, r: 4'h5, m0l: 8'b01010000, m0r: 8'b00101000,
                m1l: 8'b10100000, m1r: 8'b01010000};
    vecs[1] = '{l: 4'hF, r: 4'h1, m0l: 8'b01111000, m0r: 8'b00001000,
                m1l: 8'b11110000, m1r: 8'b00010000};
    vecs[2] = '{l: 4'h8, r: 4'h7, m0l: 8'b01000000, m0r: 8'b00111000,
                m1l: 8'b10000000, m1r: 8'b01110000};

    do_reset();

    // Table-driven: one pair accepted before the first frame, slot bits compared.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      send(vecs[v].l, vecs[v].r);
      run_to(2 * C * 17);
      chk("tbl_m0_left",  int'(slot_byte(0, 0)), int'(vecs[v].m0l));
      chk("tbl_m0_right", int'(slot_byte(0, 8)), int'(vecs[v].m0r));
      chk("tbl_m1_left",  int'(slot_byte(1, 0)), int'(vecs[v].m1l));
      chk("tbl_m1_right", int'(slot_byte(1, 8)), int'(vecs[v].m1r));
    end

    // No data: one underrun per 64-cycle frame, starting at the first frame.
    do_reset();
    und_cnt = 0;
    while (t < 256) begin
      step();
      if (und0) und_cnt++;
    end
    chk("underrun_count", und_cnt, 4);

    // Back-to-back pairs with s_valid held high.
    do_reset();
    pl[0] = 4'h3; prr[0] = 4'hC;
    pl[1] = 4'h9; prr[1] = 4'h6;
    pl[2] = 4'hE; prr[2] = 4'h2;
    idx = 0;
    s_valid = 1'b1;
    l_data = pl[0];
    r_data = prr[0];
    while (t < 200) begin
      step();
      if (last_acc && idx < 3) begin
        acc_t[idx] = t;
        idx++;
        if (idx < 3) begin
          l_data = pl[idx];
          r_data = prr[idx];
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
    chk("p_accepted", idx, 3);
    chk("p1_accept_t", acc_t[0], 1);
    chk("p2_accept_t", acc_t[1], 5);
    for (int f = 0; f < 3; f++) begin
      chk("p_frame_left",  int'(word1(f * 16)),     int'(pl[f]));
      chk("p_frame_right", int'(word1(f * 16 + 8)), int'(prr[f]));
    end

    // Reset in the middle of the right slot with a pair held.
    do_reset();
    send(4'hB, 4'hD);
    run_to(20);
    send(4'h6, 4'h9);
    run_to(48);
    chk("mid_wclk_right", int'(wclk0), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("restart_bclk_t1", int'(bclk0), 0);
    step();
    chk("restart_bclk_t2", int'(bclk0), 1);
    step();
    step();
    chk("restart_bclk_t4", int'(bclk0), 0);
    chk("restart_wclk_t4", int'(wclk0), 0);
    chk("restart_underrun", int'(und0), 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        s_valid = 1'b0;
        step();
        rst = 1'b0;
      end else begin
        s_valid = ($urandom_range(0, 2) == 0);
        l_data  = W'($urandom);
        r_data  = W'($urandom);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_master.md
I2S_TX_MASTER -- requirements
Module: i2s_tx_master

Interface
REQ-001 Parameter CLK_DIV, default 128: bclk half-period in adc_clk cycles; legal range >=1.
REQ-002 Parameter SAMPLE_W, default 24: audio sample width in bits.
REQ-003 Parameter SLOT_W, default 32: bclk periods per channel slot; SLOT_W >= SAMPLE_W+1 when MODE=0, SLOT_W >= SAMPLE_W when MODE=1.
REQ-004 Parameter MODE, default 0: 0 = Philips I2S (one-bclk MSB delay), 1 = left-justified.
REQ-005 adc_clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 l_data  in  SAMPLE_W  left sample, two's complement, MSB first on the wire.
REQ-008 r_data  in  SAMPLE_W  right sample.
REQ-009 s_valid  in  1  l_data/r_data pair valid.
REQ-010 s_ready  out  1  holding register empty; pair accepted when s_valid && s_ready.
REQ-011 i2s_bclk  out  1  bit clock.
REQ-012 i2s_wclk  out  1  word clock; 0 = left slot, 1 = right slot.
REQ-013 i2s_sdata  out  1  serial data.
REQ-014 underrun  out  1  one-cycle pulse when a frame starts with no pair held.

Function
REQ-015 clk_cnt counts 0..CLK_DIV-1 and wraps; on wrap i2s_bclk toggles, giving a bclk period of 2*CLK_DIV adc_clk cycles.
REQ-016 A falling-edge event is the adc_clk cycle where clk_cnt==CLK_DIV-1 and i2s_bclk==1; i2s_wclk, i2s_sdata, bit_cnt and frame load update only on falling-edge events.
REQ-017 On each falling-edge event bit_cnt increments; when bit_cnt==SLOT_W-1 it wraps to 0 and i2s_wclk toggles in the same cycle.
REQ-018 Frame start is the falling-edge event where i2s_wclk goes 1->0.
REQ-019 At frame start, if the holding register is full, its pair is copied to the shift registers and the holding register is marked empty.
REQ-020 At frame start, if the holding register is empty, zeros are loaded and underrun is 1 for exactly that adc_clk cycle.
REQ-021 Holding register: 1 pair deep; s_ready = !full, registered; a pair accepted in a frame-start cycle fills the holding register for the following frame and does not affect the current load.
REQ-022 Bit mapping: after each falling-edge event, with slot position p (new bit_cnt) and d = p - (MODE==0 ? 1 : 0), i2s_sdata = sample[SAMPLE_W-1-d] of the current channel when 0 <= d < SAMPLE_W, else 0.
REQ-023 Left slot uses the loaded left sample and right slot the loaded right sample; pairs are never reordered or dropped while s_ready handshakes are honoured.
REQ-024 i2s_bclk runs continuously from reset deassertion regardless of data availability.

Reset
REQ-025 While rst=1: clk_cnt=0, i2s_bclk=0, bit_cnt=SLOT_W-1, i2s_wclk=1, i2s_sdata=0, underrun=0, holding register empty, s_ready=1, shift registers 0.
REQ-026 The first falling-edge event occurs 2*CLK_DIV cycles after rst deasserts, and it is a frame start.
REQ-027 rst asserted mid-frame aborts the frame immediately; any held pair is discarded.

Verification (CLK_DIV=2, SAMPLE_W=4, SLOT_W=8 unless noted)
REQ-028 Reset release -> bclk rises at cycle 2 and falls at cycle 4; wclk 1->0 at cycle 4; s_ready=1 throughout.
REQ-029 MODE=0, pair L=4'hA, R=4'h5 accepted before first frame -> left slot sdata 0,1,0,1,0,0,0,0; right slot 0,0,1,0,1,0,0,0; no underrun.
REQ-030 MODE=1, same pair -> left slot 1,0,1,0,0,0,0,0; right slot 0,1,0,1,0,0,0,0.
REQ-031 s_valid never asserted -> sdata constantly 0; underrun pulses exactly once per frame (every 64 adc_clk cycles).
REQ-032 s_valid held high with pairs P1,P2,P3 -> P1 accepted immediately, s_ready=0 until frame start, then P2 accepted; frames carry P1,P2,P3 in order.
REQ-033 rst pulsed mid right slot -> all outputs return to REQ-025 values the next cycle; restart timing matches REQ-028.
